// File: rtl/instruction_fetch.sv
// Fetch stage in front of program memory port A: drives the word PC, captures the
// returned instruction one cycle later and buffers it in a small prefetch queue.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [29:0] mem_pc,
  input  logic [31:0] mem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_W  = (CNT_W + 1)'(DEPTH);

  logic [29:0]      next_pc_q, next_pc_d;
  logic             inflight_q, inflight_d;
  logic [29:0]      inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [29:0]      q_pc_q    [DEPTH];
  logic [29:0]      q_pc_d    [DEPTH];
  logic [31:0]      q_instr_q [DEPTH];
  logic [31:0]      q_instr_d [DEPTH];

  logic             pop;
  logic             push;
  logic             issue;
  logic [CNT_W:0]   occupancy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Handshake: an instruction transfers to decode at a clock edge where out_valid and
  // out_ready are both high and no redirect is present; a redirect voids that transfer.
  // While out_valid=1 and out_ready=0 the head (out_pc/out_instr) is held stable.
  assign out_valid = (count_q != '0);
  assign out_pc    = {q_pc_q[head_q], 2'b00};
  assign out_instr = q_instr_q[head_q];

  assign pop  = out_valid & out_ready & ~redirect_valid;
  assign push = inflight_q & ~redirect_valid;

  // Slots already claimed after this edge; a new read is only issued if it has a home.
  assign occupancy = (CNT_W + 1)'(count_q) + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
  assign issue     = fetch_en & ~redirect_valid & (occupancy < DEPTH_W);

  assign mem_pc = reset          ? RESET_PC[31:2]    :
                  redirect_valid ? redirect_pc[31:2] : next_pc_q;

  always_comb begin
    next_pc_d     = next_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    q_pc_d        = q_pc_q;
    q_instr_d     = q_instr_q;

    if (redirect_valid) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      if (fetch_en) begin
        inflight_d    = 1'b1;
        inflight_pc_d = redirect_pc[31:2];
        next_pc_d     = redirect_pc[31:2] + 30'd1;
      end else begin
        inflight_d = 1'b0;
        next_pc_d  = redirect_pc[31:2];
      end
    end else begin
      if (push) begin
        q_pc_d[tail_q]    = inflight_pc_q;
        q_instr_d[tail_q] = mem_instr;
        tail_d            = ptr_inc(tail_q);
      end
      if (pop) begin
        head_d = ptr_inc(head_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      inflight_d = issue;
      if (issue) begin
        inflight_pc_d = next_pc_q;
        next_pc_d     = next_pc_q + 30'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_pc_q     <= RESET_PC[31:2];
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc_q[i]    <= '0;
        q_instr_q[i] <= '0;
      end
    end else begin
      next_pc_q     <= next_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      q_pc_q        <= q_pc_d;
      q_instr_q     <= q_instr_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed timing scenarios plus a randomized phase, with an
// in-order stream scoreboard of expected {pc, instr} pairs.
module tb_instruction_fetch;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [29:0] mem_pc;
  logic [31:0] mem_instr = 32'h0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int checks   = 0;
  int failures = 0;
  int accepted = 0;

  logic [63:0] exp_q[$];

  instruction_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_pc(mem_pc), .mem_instr(mem_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Program memory: word w holds 0x1000_0000 + w, returned one cycle after the address.
  function automatic logic [31:0] mem_word(input logic [31:0] byte_pc);
    return 32'h1000_0000 + {2'b00, byte_pc[31:2]};
  endfunction

  always @(posedge clk) mem_instr <= mem_word({mem_pc, 2'b00});

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // After reset or a redirect, decode must see pc, pc+4, pc+8, ... in order.
  task automatic start_stream(input logic [31:0] pc);
    logic [31:0] p;
    exp_q.delete();
    p = {pc[31:2], 2'b00};
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back({p, mem_word(p)});
      p = p + 32'd4;
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic        hold_prev = 1'b0;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;

  always @(negedge clk) begin
    logic [63:0] exp;
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("stall_hold_valid", 64'(out_valid), 64'd1);
        check("stall_hold_head", {out_pc, out_instr}, {hold_pc, hold_instr});
      end
      if (out_valid && out_ready && !redirect_valid) begin
        accepted++;
        if (exp_q.size() == 0) begin
          check("exp_q_underflow", {out_pc, out_instr}, 64'hxxxx_xxxx_xxxx_xxxx);
        end else begin
          exp = exp_q.pop_front();
          check("stream_pc_instr", {out_pc, out_instr}, exp);
        end
      end
      hold_prev  = out_valid && !out_ready && !redirect_valid;
      hold_pc    = out_pc;
      hold_instr = out_instr;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ref_pc;
    logic [31:0] ref_instr;
    int seg;
    int rnd;

    reset = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    start_stream(RESET_PC);
    repeat (3) tick();
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_out_pc", 64'(out_pc), 64'd0);
    check("reset_out_instr", 64'(out_instr), 64'd0);
    check("reset_mem_pc", 64'(mem_pc), 64'(RESET_PC[31:2]));

    // Reset release: valid appears two edges later, then one instruction per cycle.
    reset = 1'b0;
    tick();
    check("lat_c1_valid", 64'(out_valid), 64'd0);
    tick();
    check("lat_c2_valid", 64'(out_valid), 64'd1);
    check("lat_c2_pc", 64'(out_pc), 64'(RESET_PC));
    for (int k = 1; k < 8; k++) begin
      tick();
      check("stream_no_bubble", 64'(out_valid), 64'd1);
      check("stream_seq_pc", 64'(out_pc), 64'(RESET_PC + 32'(4 * k)));
    end

    // Stall: queue fills to DEPTH, head stable, next issue address frozen.
    out_ready = 1'b0;
    ref_pc = out_pc;
    ref_instr = out_instr;
    repeat (3) tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_pc", 64'(out_pc), 64'(ref_pc));
      check("stall_instr", 64'(out_instr), 64'(ref_instr));
      check("stall_mem_pc", 64'(mem_pc), 64'(ref_pc[31:2] + 30'(DEPTH)));
    end
    out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("resume_valid", 64'(out_valid), 64'd1);
      check("resume_pc", 64'(out_pc), 64'(ref_pc + 32'(4 * k)));
    end

    // Redirect while the queue is full.
    out_ready = 1'b0;
    repeat (3) tick();
    check("full_before_redirect", 64'(out_valid), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    check("redirect_mem_pc", 64'(mem_pc), 64'h40);
    start_stream(32'h0000_0100);
    tick();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    check("redirect_n1_valid", 64'(out_valid), 64'd0);
    tick();
    check("redirect_n2_valid", 64'(out_valid), 64'd1);
    check("redirect_n2_pc", 64'(out_pc), 64'h100);
    tick();
    check("redirect_n3_pc", 64'(out_pc), 64'h104);

    // Redirect coinciding with a would-be pop.
    repeat (2) tick();
    check("pop_redirect_pre_valid", 64'(out_valid), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_2000;
    start_stream(32'h0000_2000);
    tick();
    redirect_valid = 1'b0;
    check("pop_redirect_flushed", 64'(out_valid), 64'd0);
    tick();
    check("pop_redirect_target", 64'(out_pc), 64'h2000);

    // Address wrap at the top of memory.
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    start_stream(32'hFFFF_FFF8);
    tick();
    redirect_valid = 1'b0;
    tick();
    check("wrap_pc0", 64'(out_pc), 64'hFFFF_FFF8);
    tick();
    check("wrap_pc1", 64'(out_pc), 64'hFFFF_FFFC);
    tick();
    check("wrap_pc2", 64'(out_pc), 64'h0);
    check("wrap_instr2", 64'(out_instr), 64'h1000_0000);

    // fetch_en low for five cycles: the in-flight read drains, then a gap.
    ref_pc = out_pc;
    fetch_en = 1'b0;
    tick();
    check("fe_off_inflight_valid", 64'(out_valid), 64'd1);
    check("fe_off_inflight_pc", 64'(out_pc), 64'(ref_pc + 32'd4));
    for (int k = 0; k < 4; k++) begin
      tick();
      check("fe_off_empty", 64'(out_valid), 64'd0);
    end
    fetch_en = 1'b1;
    tick();
    check("fe_on_n1_valid", 64'(out_valid), 64'd0);
    tick();
    check("fe_on_n2_valid", 64'(out_valid), 64'd1);
    check("fe_on_n2_pc", 64'(out_pc), 64'(ref_pc + 32'd8));

    // Reset mid-stream.
    repeat (3) tick();
    reset = 1'b1;
    start_stream(RESET_PC);
    #1;
    check("midreset_valid", 64'(out_valid), 64'd0);
    check("midreset_mem_pc", 64'(mem_pc), 64'(RESET_PC[31:2]));
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("midreset_c1_valid", 64'(out_valid), 64'd0);
    tick();
    check("midreset_c2_valid", 64'(out_valid), 64'd1);
    check("midreset_c2_pc", 64'(out_pc), 64'(RESET_PC));

    // Randomized phase: ordering and stall stability are checked by the monitor.
    accepted = 0;
    seg = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      redirect_valid = 1'b0;
      seg++;
      if (reset) begin
        reset = 1'b0;
      end else begin
        rnd = int'($urandom_range(0, 999));
        if (rnd < 5) begin
          reset = 1'b1;
          start_stream(RESET_PC);
          seg = 0;
        end else if (rnd < 40 || seg > 200) begin
          redirect_valid = 1'b1;
          redirect_pc = $urandom;
          start_stream(redirect_pc);
          seg = 0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      fetch_en  = ($urandom_range(0, 6) != 0);
    end
    redirect_valid = 1'b0;
    reset = 1'b0;
    tick();
    check("random_throughput", 64'(accepted > 300), 64'd1);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage that sits directly upstream of program memory port A. It drives the word PC into the memory and captures the returned instruction one cycle later.
- Instructions are buffered in a small prefetch queue and presented to decode with a valid/ready handshake.
- Handles the reset vector, control-flow redirects (flush plus kill of the in-flight read), and fetch enable.
- Sustains 1 instruction/cycle when decode is always ready.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset; bits [1:0] must be 0.
- DEPTH, 2, prefetch queue entries; legal values 2..8.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- fetch_en  in  1  allow new memory reads; in-flight read still completes
- redirect_valid  in  1  redirect request (branch/jump/trap)
- redirect_pc  in  32  redirect byte address; bits [1:0] ignored
- mem_pc  out  30  word address to program memory PC[31:2]; combinational
- mem_instr  in  32  program memory instr; valid the cycle after mem_pc is presented
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts
- out_pc  out  32  byte PC of head instruction, bits [1:0]=0
- out_instr  out  32  head instruction

Behaviour:
- Reset (asynchronous assert, synchronous-to-clk release):
  - queue empty; out_valid=0, out_pc=0, out_instr=0; inflight=0.
  - next_pc=RESET_PC; mem_pc=RESET_PC[31:2] while in reset.
- State:
  - next_pc[31:2]: next address to issue.
  - inflight: 1 bit.
  - inflight_pc: address of the outstanding read.
  - queue: DEPTH x {pc[31:2], instr[31:0]}, with head/tail/count.
- pop = out_valid & out_ready & !redirect_valid.
- issue = fetch_en & !redirect_valid & (count + inflight - pop < DEPTH).
- mem_pc:
  - redirect_valid=1: redirect_pc[31:2].
  - otherwise: next_pc.
  - Driven every cycle; the memory read is unconditional, so a non-issue cycle's data is simply dropped.
- Response: if inflight=1 at a clock edge, push {inflight_pc, mem_instr} into the queue, unless redirect_valid is 1 that cycle (kill).
- Issue:
  - on issue, inflight<=1, inflight_pc<=next_pc, next_pc<=next_pc+1. The 30-bit add wraps, so 0xFFFF_FFFC is followed by 0x0000_0000.
  - with no issue, inflight<=0.
- Redirect (cycle N), priority over everything:
  - queue flushed (count<=0); the in-flight response is discarded.
  - any out handshake in cycle N is void; decode must also discard its copy.
  - if fetch_en=1: inflight<=1, inflight_pc<=redirect_pc[31:2], next_pc<=redirect_pc[31:2]+1.
  - if fetch_en=0: next_pc<=redirect_pc[31:2], inflight<=0.
  - out_valid returns at N+2 with out_pc=redirect address.
- Output: out_valid=(count!=0); out_pc={head.pc,2'b00}; out_instr=head.instr. Outputs come from registers only; there is no combinational path from mem_instr.
- Stall: with out_ready=0, the queue fills to DEPTH and issue stops. The queue never overflows (guaranteed by the issue rule). Head contents are stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop: count unchanged, both pointers advance.
- fetch_en deassert: the already issued read is still pushed next cycle; no further issues.
- Reset asserted mid-operation: immediate return to the reset state; all queued and in-flight data is lost.
- Latency: reset release (cycle 0) -> mem_pc=RESET_PC[31:2] issued at cycle 0 -> pushed at cycle 1 -> out_valid=1 at cycle 2.

Test Plan:
- Reset release, out_ready=1, fetch_en=1, memory word i=32'h1000_0000+i -> out_valid rises 2 cycles after release. out_pc=0,4,8,... on consecutive cycles, with out_instr matching, no bubbles.
- Hold out_ready=0 from cycle 3 to 10, then 1 -> exactly DEPTH entries are held. out_pc/out_instr are stable during the stall. The sequence resumes with no gap or duplicate, and mem_pc is frozen while full.
- redirect_valid=1 with redirect_pc=32'h0000_0103 while 2 entries are queued -> out_valid=0 next cycle. The old entries never appear, and 2 cycles later out_pc=32'h0000_0100 followed by 0x104.
- redirect_valid and a valid pop in the same cycle -> the popped PC is not reissued. The next output is the redirect target, and count=0 after the edge.
- Redirect to 32'hFFFF_FFF8 -> outputs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 in order.
- fetch_en dropped for 5 cycles mid-stream -> the in-flight read still appears, then out_valid=0. After re-enable, fetch resumes at the next sequential PC. Assert reset mid-stream -> out_valid=0 immediately, and fetch restarts at RESET_PC.
